// File: rtl/ila_dump_ctrl.sv
// ---------------------------------------------------------------------------
// ila_dump_ctrl
//
// Readout sequencer for the ILA capture buffer. A start command latches the
// captured sample count. The block then walks every (index, value_select)
// pair of the buffer. For each word it waits out the buffer's fixed read
// latency, then presents the word on a valid/ready stream. The last beat of a
// dump is tagged with m_last_o, and completion is flagged by a one-cycle
// done_o pulse.
//
// Optional build macro:
//   ILA_DUMP_HEADER_EN - when defined, a header beat carrying the
//                        zero-extended sample count is emitted before the
//                        first data word. With a zero count the header is
//                        the only beat and carries m_last_o.
//
// Parameters:
//   DATA_W   - readout word / stream data width
//   BUFFER_W - sample index / count width
//   SEL_W    - value_select width
//   N_PARTS  - DATA_W-words per sample (1 .. 2**SEL_W)
//   READ_LAT - clk_i edges from index/value_select change to valid value_i
//
// Ports:
//   clk_i          in   system clock
//   arst_i         in   asynchronous reset, active-high
//   cke_i          in   clock enable; low freezes every register
//   start_i        in   begin a dump (sampled in IDLE only)
//   abort_i        in   terminate the dump and return to IDLE (top priority)
//   n_samples_i    in   captured sample count from the ILA core
//   index_o        out  buffer read address
//   value_select_o out  word select within a sample
//   value_i        in   read data from the ILA core
//   busy_o         out  dump in progress
//   done_o         out  one-cycle pulse at dump completion
//   m_valid_o      out  stream data valid
//   m_ready_i      in   stream sink ready
//   m_data_o       out  stream data
//   m_last_o       out  final beat of the dump
// ---------------------------------------------------------------------------
module ila_dump_ctrl #(
  parameter int DATA_W   = 32,
  parameter int BUFFER_W = 10,
  parameter int SEL_W    = 2,
  parameter int N_PARTS  = 2,
  parameter int READ_LAT = 2
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [BUFFER_W-1:0] n_samples_i,
  output logic [BUFFER_W-1:0] index_o,
  output logic [SEL_W-1:0]    value_select_o,
  input  logic [DATA_W-1:0]   value_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DATA_W-1:0]   m_data_o,
  output logic                m_last_o
);

  // The wait counter must be able to hold READ_LAT itself.
  localparam int                CNT_W    = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(READ_LAT);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_PARTS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,   // header beat on the stream (header build only)
    S_WAIT = 3'd2,   // waiting out the buffer read latency
    S_OUT  = 3'd3,   // data beat on the stream, waiting for handshake
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [BUFFER_W-1:0] r_count;
  logic [BUFFER_W-1:0] r_index;
  logic [SEL_W-1:0]    r_sel;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;
  logic                r_busy;
  logic                r_done;

  logic [BUFFER_W-1:0] w_count_next;
  logic [BUFFER_W-1:0] w_index_next;
  logic [SEL_W-1:0]    w_sel_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_valid_next;
  logic [DATA_W-1:0]   w_data_next;
  logic                w_last_next;
  logic                w_busy_next;
  logic                w_done_next;

  logic                w_handshake;
  logic                w_final_word;
  logic                w_start;

  assign w_handshake  = r_valid & m_ready_i;
  // Only evaluated in WAIT, where r_count is known to be non-zero.
  assign w_final_word = (r_index == (r_count - BUFFER_W'(1))) && (r_sel == SEL_LAST);
  // A simultaneous abort cancels a start in IDLE.
  assign w_start      = start_i & ~abort_i;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
    end else if (cke_i) begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
`ifdef ILA_DUMP_HEADER_EN
          w_state_next = S_HDR;
`else
          w_state_next = (n_samples_i == '0) ? S_DONE : S_WAIT;
`endif
        end
      end
      S_HDR: begin
        if (w_handshake) begin
          w_state_next = r_last ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (w_handshake) begin
          w_state_next = r_last ? S_DONE : S_WAIT;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Abort overrides every transition, including a start in IDLE.
    if (abort_i) begin
      w_state_next = S_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Output / datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_count_next = r_count;
    w_index_next = r_index;
    w_sel_next   = r_sel;
    w_cnt_next   = r_cnt;
    w_valid_next = r_valid;
    w_data_next  = r_data;
    w_last_next  = r_last;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_count_next = n_samples_i;
          w_index_next = '0;
          w_sel_next   = '0;
          w_cnt_next   = '0;
`ifdef ILA_DUMP_HEADER_EN
          w_valid_next = 1'b1;
          w_data_next  = DATA_W'(n_samples_i);
          w_last_next  = (n_samples_i == '0);
`endif
        end
      end
      S_HDR: begin
        // Address is already (0,0), so the first WAIT can start directly.
        if (w_handshake) begin
          w_valid_next = 1'b0;
          w_last_next  = 1'b0;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          // Counter is re-armed here so the next WAIT entry starts from 0.
          w_cnt_next   = '0;
          w_valid_next = 1'b1;
          w_data_next  = value_i;
          w_last_next  = w_final_word;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (w_handshake) begin
          w_valid_next = 1'b0;
          w_last_next  = 1'b0;
          // On the final beat the address is left where it is so it never
          // steps past count-1.
          if (!r_last) begin
            if (r_sel == SEL_LAST) begin
              w_sel_next   = '0;
              w_index_next = r_index + BUFFER_W'(1);
            end else begin
              w_sel_next   = r_sel + SEL_W'(1);
            end
          end
        end
      end
      default: begin
      end
    endcase

    // A pending beat is simply dropped; the sink has to tolerate it.
    if (abort_i) begin
      w_valid_next = 1'b0;
      w_last_next  = 1'b0;
      w_index_next = '0;
      w_sel_next   = '0;
      w_cnt_next   = '0;
    end

    w_busy_next = (w_state_next != S_IDLE);
    w_done_next = (w_state_next == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath / output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_count <= '0;
      r_index <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (cke_i) begin
      r_count <= w_count_next;
      r_index <= w_index_next;
      r_sel   <= w_sel_next;
      r_cnt   <= w_cnt_next;
      r_valid <= w_valid_next;
      r_data  <= w_data_next;
      r_last  <= w_last_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign index_o        = r_index;
  assign value_select_o = r_sel;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign m_valid_o      = r_valid;
  assign m_data_o       = r_data;
  assign m_last_o       = r_last;

endmodule

// File: tb/tb_ila_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ila_dump_ctrl
//
// Bench for ila_dump_ctrl. An ILA buffer model returns mem[{index,select}]
// READ_LAT edges after the address changes. For every dump, a reference
// list of beats is built from the latched count. A monitor compares each
// accepted beat against that list, and the dump tasks check latency,
// back-pressure, abort, clock-enable and reset behaviour.
// ---------------------------------------------------------------------------
module tb_ila_dump_ctrl;

  localparam int DATA_W   = 32;
  localparam int BUFFER_W = 10;
  localparam int SEL_W    = 2;
  localparam int N_PARTS  = 2;
  localparam int READ_LAT = 2;
  localparam int ADDR_W   = BUFFER_W + SEL_W;
`ifdef ILA_DUMP_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic                clk_i;
  logic                arst_i;
  logic                cke_i;
  logic                start_i;
  logic                abort_i;
  logic [BUFFER_W-1:0] n_samples_i;
  logic [BUFFER_W-1:0] index_o;
  logic [SEL_W-1:0]    value_select_o;
  logic [DATA_W-1:0]   value_i;
  logic                busy_o;
  logic                done_o;
  logic                m_valid_o;
  logic                m_ready_i;
  logic [DATA_W-1:0]   m_data_o;
  logic                m_last_o;

  ila_dump_ctrl #(
    .DATA_W  (DATA_W),
    .BUFFER_W(BUFFER_W),
    .SEL_W   (SEL_W),
    .N_PARTS (N_PARTS),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .cke_i         (cke_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .n_samples_i   (n_samples_i),
    .index_o       (index_o),
    .value_select_o(value_select_o),
    .value_i       (value_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // -------------------------------------------------------------------------
  // ILA buffer model: free-running read pipeline of depth READ_LAT
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] mem  [1 << ADDR_W];
  logic [DATA_W-1:0] pipe [READ_LAT];

  always @(posedge clk_i) begin
    pipe[0] <= mem[{index_o, value_select_o}];
    for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign value_i = pipe[READ_LAT-1];

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_index"}, 64'(index_o),        64'(0));
    check({tag, "_sel"},   64'(value_select_o), 64'(0));
    check({tag, "_valid"}, 64'(m_valid_o),      64'(0));
    check({tag, "_data"},  64'(m_data_o),       64'(0));
    check({tag, "_last"},  64'(m_last_o),       64'(0));
    check({tag, "_busy"},  64'(busy_o),         64'(0));
    check({tag, "_done"},  64'(done_o),         64'(0));
  endtask

  // -------------------------------------------------------------------------
  // Reference beat list
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t exp_q[$];

  task automatic build_expect(input int n);
    beat_t               b;
    logic [ADDR_W-1:0]   a;
    int                  total;
    total = n * N_PARTS + HDR;
    if (HDR != 0) begin
      b.data = DATA_W'(n);
      b.last = (total == 1);
      exp_q.push_back(b);
    end
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < N_PARTS; s++) begin
        a      = {BUFFER_W'(i), SEL_W'(s)};
        b.data = mem[a];
        b.last = (i == n - 1) && (s == N_PARTS - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor: samples 3 time units after the falling edge, after the input
  // driver has settled and well before the next rising edge.
  // -------------------------------------------------------------------------
  int    n_acc_total    = 0;
  int    cyc            = 0;
  int    last_acc_cyc   = 0;
  bit    last_acc_valid = 1'b0;
  beat_t mb;

  always begin
    @(negedge clk_i);
    #3;
    cyc++;
    if (arst_i || abort_i) begin
      last_acc_valid = 1'b0;
    end else begin
      if (m_valid_o) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 64'(1), 64'(0));
        end else if (m_ready_i && cke_i) begin
          mb = exp_q.pop_front();
          check("beat_data", 64'(m_data_o), 64'(mb.data));
          check("beat_last", 64'(m_last_o), 64'(mb.last));
          n_acc_total++;
          last_acc_cyc   = cyc;
          last_acc_valid = 1'b1;
        end else begin
          check("beat_hold", 64'(m_data_o), 64'(exp_q[0].data));
        end
      end
      if (done_o) begin
        check("done_q_empty", 64'(exp_q.size()), 64'(0));
        if (last_acc_valid) check("done_after_last", 64'(cyc - last_acc_cyc), 64'(1));
        last_acc_valid = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sink ready / clock-enable driver
  // -------------------------------------------------------------------------
  bit rand_mode = 1'b0;
  bit dir_ready = 1'b1;
  bit dir_cke   = 1'b1;

  initial begin
    m_ready_i = 1'b1;
    cke_i     = 1'b1;
    forever begin
      @(negedge clk_i);
      #1;
      if (rand_mode) begin
        m_ready_i = ($urandom_range(0, 3) != 0);
        cke_i     = ($urandom_range(0, 7) != 0);
      end else begin
        m_ready_i = dir_ready;
        cke_i     = dir_cke;
      end
    end
  end

  // -------------------------------------------------------------------------
  // One dump. exp_lat < 0 skips the latency check, cke_at > 0 freezes the
  // clock for 5 cycles from that cycle, bp stalls beat 2 for 10 cycles,
  // abort_at >= 0 aborts while that many beats have completed.
  // -------------------------------------------------------------------------
  task automatic run_dump(input int n, input int exp_lat, input int cke_at,
                          input bit bp, input int abort_at, input bit scramble);
    int                  c, first, busy_cnt, bound, base, bp_left, d;
    bit                  started, got_done, aborted, bp_used;
    logic [BUFFER_W-1:0] bp_idx;
    logic [SEL_W-1:0]    bp_sel;
    c = 0; first = -1; busy_cnt = 0; bp_left = 0;
    started = 0; got_done = 0; aborted = 0; bp_used = 0;
    bp_idx = '0; bp_sel = '0;

    for (int w = 0; w < 64 && busy_o; w++) @(negedge clk_i);
    check("idle_before_start", 64'(busy_o), 64'(0));

    build_expect(n);
    base  = n_acc_total;
    bound = (n * N_PARTS + 2) * (READ_LAT + 2) * 8 + 64;
    n_samples_i = BUFFER_W'(n);
    start_i     = 1'b1;

    while (!got_done && !aborted && c < bound) begin
      @(negedge clk_i);
      c++;
      if (!started) begin
        if (busy_o) begin
          started = 1;
          start_i = 1'b0;
        end
      end else if (scramble) begin
        start_i     = 1'($urandom_range(0, 1));
        n_samples_i = BUFFER_W'($urandom);
      end
      if (busy_o) busy_cnt++;
      if (m_valid_o && first < 0) first = c;

      if (cke_at > 0 && c == cke_at)     dir_cke = 1'b0;
      if (cke_at > 0 && c == cke_at + 5) dir_cke = 1'b1;

      if (bp && !bp_used && (n_acc_total - base) == 1 && m_valid_o) begin
        bp_used   = 1;
        bp_left   = 10;
        dir_ready = 1'b0;
        d         = 1 - HDR;
        bp_idx    = BUFFER_W'(d / N_PARTS);
        bp_sel    = SEL_W'(d % N_PARTS);
      end else if (bp_left > 0) begin
        check("bp_valid", 64'(m_valid_o),      64'(1));
        check("bp_index", 64'(index_o),        64'(bp_idx));
        check("bp_sel",   64'(value_select_o), 64'(bp_sel));
        bp_left--;
        if (bp_left == 0) dir_ready = 1'b1;
      end

      if (abort_at >= 0 && started && (n_acc_total - base) == abort_at && m_valid_o) begin
        start_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort_valid", 64'(m_valid_o),      64'(0));
        check("abort_last",  64'(m_last_o),       64'(0));
        check("abort_busy",  64'(busy_o),         64'(0));
        check("abort_done",  64'(done_o),         64'(0));
        check("abort_index", 64'(index_o),        64'(0));
        check("abort_sel",   64'(value_select_o), 64'(0));
        exp_q.delete();
        aborted = 1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          check("abort_no_done",  64'(done_o),    64'(0));
          check("abort_no_valid", 64'(m_valid_o), 64'(0));
        end
      end

      if (started && done_o) begin
        got_done = 1;
        start_i  = 1'b0;
      end
    end

    start_i = 1'b0;
    if (!aborted) begin
      check("done_seen", 64'(got_done), 64'(1));
      check("beat_count", 64'(n_acc_total - base), 64'(n * N_PARTS + HDR));
      if (exp_lat >= 0) check("first_valid_lat", 64'(first), 64'(exp_lat));
      if (n == 0) check("busy_zero_le2", 64'(busy_cnt <= 2), 64'(1));
      if (!got_done) exp_q.delete();
      if (!rand_mode) begin
        @(negedge clk_i);
        check("post_busy", 64'(busy_o),   64'(0));
        check("post_last", 64'(m_last_o), 64'(0));
      end
    end
    $display("dump n=%0d beats=%0d cycles=%0d aborted=%0d", n, n_acc_total - base, c, aborted);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [ADDR_W-1:0] a;
    int                ok;
    arst_i      = 1'b1;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    n_samples_i = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      a      = ADDR_W'(i);
      mem[a] = DATA_W'(($urandom() << ADDR_W) | i);
    end

    repeat (3) @(negedge clk_i);
    check_zero("rst");
    arst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_zero("rst_rel");

    // Basic dump, back-pressure, zero count.
    run_dump(3, (HDR != 0) ? 1 : READ_LAT + 2, 0, 0, -1, 0);
    run_dump(3, -1, 0, 1, -1, 0);
    run_dump(0, -1, 0, 0, -1, 0);

    // Abort during beat 3 of 8, with start/count noise on the inputs.
    run_dump(4, -1, 0, 0, 2, 1);

    // Clock enable low for 5 cycles during the first WAIT.
    run_dump(2, (HDR != 0) ? 1 : READ_LAT + 2 + 5, 1, 0, -1, 0);

    // Asynchronous reset while a beat is presented.
    n_samples_i = BUFFER_W'(5);
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    ok = 0;
    for (int w = 0; w < 40 && !m_valid_o; w++) @(negedge clk_i);
    check("rst_mid_reached_out", 64'(m_valid_o), 64'(1));
    arst_i = 1'b1;
    #1;
    check_zero("rst_mid");
    exp_q.delete();
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    check_zero("rst_mid_rel");
    run_dump(2, (HDR != 0) ? 1 : READ_LAT + 2, 0, 0, -1, 0);

    // Full buffer: index must stop at count-1.
    run_dump((1 << BUFFER_W) - 1, -1, 0, 0, -1, 0);
    check("full_last_index", 64'(index_o),        64'((1 << BUFFER_W) - 2));
    check("full_last_sel",   64'(value_select_o), 64'(N_PARTS - 1));

    // Randomised dumps with random ready / clock enable and input noise.
    rand_mode = 1'b1;
    for (int t = 0; t < 25; t++) begin
      run_dump($urandom_range(0, 8), -1, 0, 0, -1, 1);
    end
    rand_mode = 1'b0;
    repeat (4) @(negedge clk_i);
    check("final_idle", 64'(busy_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
